ps2_keypad: RTL

Synchronous PS/2 keyboard front end. Receives PS/2 device-to-host frames and decodes set-2 scancodes, including F0 break and E0 extended prefixes. Produces the 16-bit CHIP-8 key matrix consumed by the cpu keyMatrix input. Runs entirely in one fast clock domain (vga_clk, 25.152 MHz) and replaces the ps2in decoder and the ad-hoc matrix logic clocked by its ready strobe.

---
 rtl/ps2_keypad.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keypad.sv
// PS/2 set-2 keyboard front end: synchronises and filters the PS/2 lines, deframes bytes,
// and turns make/break scancodes into a 16-key CHIP-8 key matrix plus per-key events.
module ps2_keypad #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_matrix,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic        frame_error
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_OK,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk;
    logic                  filt_clk_d;
    logic                  strobe_c;
    logic                  din_c;

    state_t                state, state_nx;
    logic [7:0]            shift_q, shift_nx;
    logic [2:0]            bitcnt_q, bitcnt_nx;
    logic                  par_ok_q, par_ok_nx;
    logic [TO_W-1:0]       tocnt_q, tocnt_nx;
    logic                  byte_valid, byte_valid_nx;
    logic                  timeout_q, timeout_nx;
    logic                  ferr_nx;

    logic                  break_flag;
    logic                  ext_flag;
    logic                  map_hit_c;
    logic [3:0]            map_key_c;

    // Synchronisers and clock filter; everything resets to the idle-high line level
    // so that leaving reset never looks like a falling PS/2 clock.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            clk_sync   <= '1;
            dat_sync   <= '1;
            filt_sr    <= '1;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            filt_sr    <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
            if (filt_sr == '0) begin
                filt_clk <= 1'b0;
            end else if (filt_sr == '1) begin
                filt_clk <= 1'b1;
            end
            filt_clk_d <= filt_clk;
        end
    end

    assign strobe_c = filt_clk_d & ~filt_clk;
    assign din_c    = dat_sync[1];

    // Frame state and datapath registers
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state       <= S_IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            par_ok_q    <= 1'b0;
            tocnt_q     <= '0;
            byte_valid  <= 1'b0;
            timeout_q   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nx;
            shift_q     <= shift_nx;
            bitcnt_q    <= bitcnt_nx;
            par_ok_q    <= par_ok_nx;
            tocnt_q     <= tocnt_nx;
            byte_valid  <= byte_valid_nx;
            timeout_q   <= timeout_nx;
            frame_error <= ferr_nx;
        end
    end

    // Frame deserialiser next state; the timeout overrides whatever the frame logic chose.
    always_comb begin
        state_nx      = state;
        shift_nx      = shift_q;
        bitcnt_nx     = bitcnt_q;
        par_ok_nx     = par_ok_q;
        tocnt_nx      = tocnt_q;
        byte_valid_nx = 1'b0;
        timeout_nx    = 1'b0;
        ferr_nx       = 1'b0;

        if (state != S_IDLE) begin
            tocnt_nx = tocnt_q + TO_W'(1);
        end
        if (strobe_c) begin
            tocnt_nx = '0;
        end

        case (state)
            S_IDLE: begin
                if (strobe_c && !din_c) begin
                    state_nx  = S_START_OK;
                    bitcnt_nx = '0;
                end
            end
            S_START_OK, S_DATA: begin
                if (strobe_c) begin
                    shift_nx  = {din_c, shift_q[7:1]};
                    bitcnt_nx = bitcnt_q + 3'd1;
                    state_nx  = (bitcnt_q == 3'd7) ? S_PARITY : S_DATA;
                end
            end
            S_PARITY: begin
                if (strobe_c) begin
                    par_ok_nx = (^shift_q) ^ din_c;
                    state_nx  = S_STOP;
                end
            end
            S_STOP: begin
                if (strobe_c) begin
                    if (din_c && par_ok_q) begin
                        byte_valid_nx = 1'b1;
                    end else begin
                        ferr_nx = 1'b1;
                    end
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (state != S_IDLE && !strobe_c && tocnt_q == TO_LAST) begin
            state_nx   = S_IDLE;
            tocnt_nx   = '0;
            ferr_nx    = 1'b1;
            timeout_nx = 1'b1;
        end
    end

    // Set-2 scancode to CHIP-8 hex keypad position
    always_comb begin
        map_hit_c = 1'b1;
        map_key_c = 4'h0;
        case (shift_q)
            8'h16: map_key_c = 4'h1;
            8'h1E: map_key_c = 4'h2;
            8'h26: map_key_c = 4'h3;
            8'h25: map_key_c = 4'hC;
            8'h15: map_key_c = 4'h4;
            8'h1D: map_key_c = 4'h5;
            8'h24: map_key_c = 4'h6;
            8'h2D: map_key_c = 4'hD;
            8'h1C: map_key_c = 4'h7;
            8'h1B: map_key_c = 4'h8;
            8'h23: map_key_c = 4'h9;
            8'h2B: map_key_c = 4'hE;
            8'h1A: map_key_c = 4'hA;
            8'h22: map_key_c = 4'h0;
            8'h21: map_key_c = 4'hB;
            8'h2A: map_key_c = 4'hF;
            default: map_hit_c = 1'b0;
        endcase
    end

    // Scancode decoder; shift_q still holds the received byte while byte_valid is high.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
            key_matrix <= '0;
            key_event  <= 1'b0;
            key_code   <= '0;
            key_down   <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (timeout_q) begin
                break_flag <= 1'b0;
                ext_flag   <= 1'b0;
            end else if (byte_valid) begin
                if (shift_q == 8'hF0) begin
                    break_flag <= 1'b1;
                end else if (shift_q == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else begin
                    break_flag <= 1'b0;
                    ext_flag   <= 1'b0;
                    if (!ext_flag && map_hit_c) begin
                        key_matrix[map_key_c] <= ~break_flag;
                        key_event             <= 1'b1;
                        key_code              <= map_key_c;
                        key_down              <= ~break_flag;
                    end
                end
            end
        end
    end

endmodule
